// File: rtl/prod_acc_pkg.sv
// Shared types and default widths for the product accumulator and later MAC stages.
package prod_acc_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } acc_state_t;

    localparam int PROD_W_DEF = 8;
    localparam int ACC_W_DEF  = 16;

endpackage

// File: rtl/prod_acc_add_sat.sv
// Combinational ACC_W-bit adder with carry out; clamps to all-ones when
// PROD_ACC_SAT_EN is defined, otherwise wraps modulo 2^ACC_W.
module acc_add_sat #(
    parameter int ACC_W = 16
) (
    input  logic [ACC_W-1:0] a,
    input  logic [ACC_W-1:0] b,
    input  logic             clamp_in,
    output logic [ACC_W-1:0] sum,
    output logic             carry
);

    logic [ACC_W:0] full;

    assign full  = {1'b0, a} + {1'b0, b};
    assign carry = full[ACC_W];

`ifdef PROD_ACC_SAT_EN
    // Once clamped, the frame stays pinned at the maximum.
    assign sum = (carry || clamp_in) ? {ACC_W{1'b1}} : full[ACC_W-1:0];
`else
    logic unused_clamp;
    assign unused_clamp = clamp_in;
    assign sum          = full[ACC_W-1:0];
`endif

endmodule

// File: rtl/prod_accumulator.sv
// Sums up to LEN multiplier products per frame and presents the result on a
// valid/ready port. Optional saturation: define PROD_ACC_SAT_EN.
module prod_accumulator
    import prod_acc_pkg::*;
#(
    parameter  int PROD_W = PROD_W_DEF,
    parameter  int ACC_W  = ACC_W_DEF,
    parameter  int LEN    = 4,
    localparam int CNT_W  = $clog2(LEN + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_prod,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_ovf
);

    if (ACC_W < PROD_W) begin : g_chk_w
        $error("ACC_W must be >= PROD_W");
    end
    if (LEN < 1) begin : g_chk_len
        $error("LEN must be >= 1");
    end

    acc_state_t       state;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             ovf;

    logic [ACC_W-1:0] sum_nxt;
    logic             carry;
    logic [CNT_W-1:0] cnt_nxt;
    logic             ovf_nxt;
    logic             accept;
    logic             frame_end;

    acc_add_sat #(.ACC_W(ACC_W)) u_add (
        .a        (acc),
        .b        (ACC_W'(in_prod)),
        .clamp_in (ovf),
        .sum      (sum_nxt),
        .carry    (carry)
    );

    assign cnt_nxt   = cnt + 1'b1;
    assign ovf_nxt   = ovf | carry;
    assign accept    = in_valid && in_ready;
    assign frame_end = (cnt_nxt == CNT_W'(LEN)) || in_last;

    // Handshake flags are registered and only change with the state, so the
    // HOLD cycle never overlaps with intake even when out_ready is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ACCUM;
            acc       <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_count <= '0;
            out_ovf   <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (accept) begin
                        acc <= sum_nxt;
                        cnt <= cnt_nxt;
                        ovf <= ovf_nxt;
                        if (frame_end) begin
                            state     <= HOLD;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                            out_sum   <= sum_nxt;
                            out_count <= cnt_nxt;
                            out_ovf   <= ovf_nxt;
                        end
                    end
                end
                HOLD: begin
                    // out_sum/out_count/out_ovf keep their value after the handoff.
                    if (out_ready) begin
                        state     <= ACCUM;
                        acc       <= '0;
                        cnt       <= '0;
                        ovf       <= 1'b0;
                        in_ready  <= 1'b1;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= ACCUM;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prod_accumulator.sv
// Directed bench for prod_accumulator: default-width instance plus an
// ACC_W=9 instance for the overflow/saturation case.
module tb_prod_accumulator;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b1;
    logic [7:0] in_prod = '0;
    logic       in_ready, out_valid, out_ovf;
    logic [15:0] out_sum;
    logic [2:0] out_count;

    logic       v9 = 1'b0, l9 = 1'b0, ordy9 = 1'b1;
    logic [7:0] p9 = '0;
    logic       rdy9, ov9, ovf9;
    logic [8:0] sum9;
    logic [2:0] cnt9;

    int n_cmp = 0;
    int n_bad = 0;

`ifdef PROD_ACC_SAT_EN
    localparam int OVF_SUM = 511;
`else
    localparam int OVF_SUM = 8;
`endif

    always #5 clk = ~clk;

    prod_accumulator dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_prod(in_prod), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_count(out_count), .out_ovf(out_ovf)
    );

    prod_accumulator #(.ACC_W(9)) dut9 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(v9), .in_ready(rdy9), .in_prod(p9), .in_last(l9),
        .out_valid(ov9), .out_ready(ordy9),
        .out_sum(sum9), .out_count(cnt9), .out_ovf(ovf9)
    );

    // One beat on the default instance; waits (bounded) for in_ready first.
    task automatic beat(input logic [7:0] p, input logic last);
        int w = 0;
        while (in_ready !== 1'b1 && w < 20) begin
            @(posedge clk); #1;
            w++;
        end
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL beat_ready_timeout got %b want 1", in_ready);
        end
        in_valid = 1'b1; in_prod = p; in_last = last;
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic beat9(input logic [7:0] p);
        v9 = 1'b1; p9 = p;
        @(posedge clk); #1;
        v9 = 1'b0;
    endtask

    task automatic test_reset;
        #12;
        n_cmp++; if (in_ready !== 1'b1)  begin n_bad++; $display("FAIL rst_in_ready got %b want 1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
        n_cmp++; if (out_sum !== 16'd0)  begin n_bad++; $display("FAIL rst_out_sum got %0d want 0", out_sum); end
        n_cmp++; if (out_count !== 3'd0) begin n_bad++; $display("FAIL rst_out_count got %0d want 0", out_count); end
        n_cmp++; if (out_ovf !== 1'b0)   begin n_bad++; $display("FAIL rst_out_ovf got %b want 0", out_ovf); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_full_frame;
        logic [7:0] p [4] = '{8'd15, 8'd18, 8'd15, 8'd81};
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            beat(p[i], 1'b0);
            if (i < 3) begin
                n_cmp++;
                if (out_valid !== 1'b0) begin n_bad++; $display("FAIL full_early_valid beat %0d got %b want 0", i, out_valid); end
            end
        end
        n_cmp++; if (out_valid !== 1'b1)  begin n_bad++; $display("FAIL full_valid got %b want 1", out_valid); end
        n_cmp++; if (out_sum !== 16'd129) begin n_bad++; $display("FAIL full_sum got %0d want 129", out_sum); end
        n_cmp++; if (out_count !== 3'd4)  begin n_bad++; $display("FAIL full_count got %0d want 4", out_count); end
        n_cmp++; if (out_ovf !== 1'b0)    begin n_bad++; $display("FAIL full_ovf got %b want 0", out_ovf); end
        n_cmp++; if (in_ready !== 1'b0)   begin n_bad++; $display("FAIL full_hold_ready got %b want 0", in_ready); end
        @(posedge clk); #1;
        n_cmp++; if (out_valid !== 1'b0)  begin n_bad++; $display("FAIL full_drop_valid got %b want 0", out_valid); end
        n_cmp++; if (in_ready !== 1'b1)   begin n_bad++; $display("FAIL full_ready_back got %b want 1", in_ready); end
        n_cmp++; if (out_sum !== 16'd129) begin n_bad++; $display("FAIL full_sum_kept got %0d want 129", out_sum); end
    endtask

    task automatic test_early_end;
        beat(8'd3, 1'b0);
        beat(8'd7, 1'b1);
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL early_valid got %b want 1", out_valid); end
        n_cmp++; if (out_sum !== 16'd10) begin n_bad++; $display("FAIL early_sum got %0d want 10", out_sum); end
        n_cmp++; if (out_count !== 3'd2) begin n_bad++; $display("FAIL early_count got %0d want 2", out_count); end
        @(posedge clk); #1;
        beat(8'd5, 1'b1);
        n_cmp++; if (out_sum !== 16'd5)  begin n_bad++; $display("FAIL first_last_sum got %0d want 5", out_sum); end
        n_cmp++; if (out_count !== 3'd1) begin n_bad++; $display("FAIL first_last_count got %0d want 1", out_count); end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure;
        logic [7:0] p [4] = '{8'd15, 8'd18, 8'd15, 8'd81};
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) beat(p[i], 1'b0);
        in_valid = 1'b1; in_prod = 8'd99; in_last = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            n_cmp++; if (out_valid !== 1'b1)  begin n_bad++; $display("FAIL bp_valid cyc %0d got %b want 1", i, out_valid); end
            n_cmp++; if (out_sum !== 16'd129) begin n_bad++; $display("FAIL bp_sum cyc %0d got %0d want 129", i, out_sum); end
            n_cmp++; if (in_ready !== 1'b0)   begin n_bad++; $display("FAIL bp_ready cyc %0d got %b want 0", i, in_ready); end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_accept_valid got %b want 0", out_valid); end
        n_cmp++; if (in_ready !== 1'b1)  begin n_bad++; $display("FAIL bp_accept_ready got %b want 1", in_ready); end
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
        n_cmp++; if (out_sum !== 16'd99) begin n_bad++; $display("FAIL bp_held_sum got %0d want 99", out_sum); end
        n_cmp++; if (out_count !== 3'd1) begin n_bad++; $display("FAIL bp_held_count got %0d want 1", out_count); end
        @(posedge clk); #1;
    endtask

    task automatic test_overflow;
        beat9(8'd255);
        beat9(8'd255);
        beat9(8'd10);
        beat9(8'd0);
        n_cmp++; if (ov9 !== 1'b1)                  begin n_bad++; $display("FAIL ovf_valid got %b want 1", ov9); end
        n_cmp++; if (sum9 !== 9'(OVF_SUM))          begin n_bad++; $display("FAIL ovf_sum got %0d want %0d", sum9, OVF_SUM); end
        n_cmp++; if (ovf9 !== 1'b1)                 begin n_bad++; $display("FAIL ovf_flag got %b want 1", ovf9); end
        n_cmp++; if (cnt9 !== 3'd4)                 begin n_bad++; $display("FAIL ovf_count got %0d want 4", cnt9); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid;
        beat(8'd81, 1'b0);
        beat(8'd81, 1'b0);
        rst_n = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rmid_valid got %b want 0", out_valid); end
        n_cmp++; if (out_sum !== 16'd0)  begin n_bad++; $display("FAIL rmid_sum got %0d want 0", out_sum); end
        n_cmp++; if (out_count !== 3'd0) begin n_bad++; $display("FAIL rmid_count got %0d want 0", out_count); end
        n_cmp++; if (in_ready !== 1'b1)  begin n_bad++; $display("FAIL rmid_ready got %b want 1", in_ready); end
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 1; i <= 4; i++) beat(8'(i), 1'b0);
        n_cmp++; if (out_sum !== 16'd10) begin n_bad++; $display("FAIL rmid_next_sum got %0d want 10", out_sum); end
        n_cmp++; if (out_count !== 3'd4) begin n_bad++; $display("FAIL rmid_next_count got %0d want 4", out_count); end
        @(posedge clk); #1;
    endtask

    task automatic test_gaps;
        logic [7:0] p [4] = '{8'd0, 8'd150, 8'd0, 8'd150};
        for (int i = 0; i < 4; i++) begin
            beat(p[i], 1'b0);
            if (i < 3) begin
                @(posedge clk); #1;
                n_cmp++;
                if (out_valid !== 1'b0) begin n_bad++; $display("FAIL gap_valid idle %0d got %b want 0", i, out_valid); end
            end
        end
        n_cmp++; if (out_valid !== 1'b1)  begin n_bad++; $display("FAIL gap_valid got %b want 1", out_valid); end
        n_cmp++; if (out_sum !== 16'd300) begin n_bad++; $display("FAIL gap_sum got %0d want 300", out_sum); end
        n_cmp++; if (out_count !== 3'd4)  begin n_bad++; $display("FAIL gap_count got %0d want 4", out_count); end
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_full_frame();
        test_early_end();
        test_backpressure();
        test_overflow();
        test_reset_mid();
        test_gaps();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
